// File: rtl/axil_arb_pkg.sv
// rtl/axil_arb_pkg.sv - shared state encodings for the cfg-port arbiter
package axil_arb_pkg;
  localparam int ARB_FSM_BIT = 2;

  typedef enum logic [ARB_FSM_BIT-1:0] {
    ARB_IDLE  = 2'b01,
    ARB_ISSUE = 2'b10
  } arb_state_t;
endpackage

// File: rtl/axil_rr_pick.sv
// rtl/axil_rr_pick.sv - round-robin pick: first set request after ptr, wrapping
module axil_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);
  logic [NUM_REQ-1:0] rot;
  logic               found;
  int                 base;
  int                 off;
  int                 sel;

  always_comb begin
    base  = (int'(ptr) + 1) % NUM_REQ;
    rot   = '0;
    found = 1'b0;
    off   = 0;
    gnt   = '0;
    // rot[0] is the requester immediately after ptr
    for (int k = 0; k < NUM_REQ; k++) begin
      rot[k] = req[IDX_W'((base + k) % NUM_REQ)];
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sel = (base + off) % NUM_REQ;
    if (found) gnt[IDX_W'(sel)] = 1'b1;
    idx = IDX_W'(sel);
  end
endmodule

// File: rtl/axil_cfg_arbiter.sv
// rtl/axil_cfg_arbiter.sv - round-robin arbiter feeding the write master cfg port
// AXIL_ARB_PRIO0_EN: requester 0 gets absolute priority, the rest round-robin.
module axil_cfg_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,
  input  logic [NUM_REQ-1:0]          req_wvalid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_waddr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_wready,
  output logic                        m_cfg_wvalid,
  output logic [ADDR_W-1:0]           m_cfg_waddr,
  output logic [DATA_W-1:0]           m_cfg_wdata,
  input  logic                        m_cfg_wready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state;
  arb_state_t         state_nx;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               prio0;
  logic               accept;

`ifdef AXIL_ARB_PRIO0_EN
  // requester 0 bypasses the rotation and never moves ptr
  assign prio0    = req_wvalid[0];
  assign pick_req = {req_wvalid[NUM_REQ-1:1], 1'b0};
`else
  assign prio0    = 1'b0;
  assign pick_req = req_wvalid;
`endif

  axil_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (pick_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign win_gnt = prio0 ? NUM_REQ'(1) : pick_gnt;
  assign win_idx = prio0 ? '0 : pick_idx;
  assign busy    = (state == ARB_ISSUE);

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) state <= ARB_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_wready = '0;
    accept     = 1'b0;
    case (state)
      ARB_IDLE: begin
        accept     = |win_gnt;
        req_wready = s_axi_areset ? '0 : win_gnt;
        if (accept) state_nx = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        if (m_cfg_wready) state_nx = ARB_IDLE;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      m_cfg_wvalid <= 1'b0;
      m_cfg_waddr  <= '0;
      m_cfg_wdata  <= '0;
      grant_id     <= '0;
      ptr          <= IDX_W'(NUM_REQ - 1);
    end else if (state == ARB_IDLE && accept) begin
      m_cfg_wvalid <= 1'b1;
      m_cfg_waddr  <= req_waddr[int'(win_idx)*ADDR_W +: ADDR_W];
      m_cfg_wdata  <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
      grant_id     <= win_idx;
      if (!prio0) ptr <= win_idx;
    end else if (state == ARB_ISSUE && m_cfg_wready) begin
      m_cfg_wvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_cfg_arbiter.sv
// tb/tb_axil_cfg_arbiter.sv - scoreboard bench for axil_cfg_arbiter
module tb_axil_cfg_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_wvalid;
  logic [N*AW-1:0] req_waddr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_wready;
  logic            m_cfg_wvalid;
  logic [AW-1:0]   m_cfg_waddr;
  logic [DW-1:0]   m_cfg_wdata;
  logic            m_cfg_wready;
  logic [1:0]      grant_id;
  logic            busy;

  axil_cfg_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .req_wvalid   (req_wvalid),
    .req_waddr    (req_waddr),
    .req_wdata    (req_wdata),
    .req_wready   (req_wready),
    .m_cfg_wvalid (m_cfg_wvalid),
    .m_cfg_waddr  (m_cfg_waddr),
    .m_cfg_wdata  (m_cfg_wdata),
    .m_cfg_wready (m_cfg_wready),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [N-1:0] cur_valid;
  logic [31:0]  cur_addr[N];
  logic [31:0]  cur_data[N];
  int           wait_cnt[N];
  bit           gen_en;
  bit           refill_en;

  bit           m_busy;
  int           m_ptr;
  int           m_id;
  logic [31:0]  m_addr;
  logic [31:0]  m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef AXIL_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (c != 0 && v[c]) return c;
    end
`else
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
    cur_valid[i] = 1'b1;
    cur_addr[i]  = a;
    cur_data[i]  = d;
    wait_cnt[i]  = 0;
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_ptr  = N - 1;
    m_id   = 0;
    m_addr = '0;
    m_data = '0;
    sb.delete();
    cur_valid = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // one clock: drive at posedge+1, check at negedge, advance the model after posedge
  task automatic cycle(input bit rdy);
    logic [N-1:0] exp_rdy;
    int w;
    req_wvalid   = cur_valid;
    for (int i = 0; i < N; i++) begin
      req_waddr[i*AW +: AW] = cur_addr[i];
      req_wdata[i*DW +: DW] = cur_data[i];
    end
    m_cfg_wready = rdy;
    w       = (!m_busy && |cur_valid) ? pick(cur_valid, m_ptr) : -1;
    exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
    @(negedge clk);
    chk("req_wready", 64'(req_wready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("m_cfg_wvalid", 64'(m_cfg_wvalid), 64'(m_busy));
    chk("m_cfg_waddr_hold", 64'(m_cfg_waddr), 64'(m_addr));
    chk("m_cfg_wdata_hold", 64'(m_cfg_wdata), 64'(m_data));
    chk("grant_id", 64'(grant_id), 64'(m_id));
    @(posedge clk);
    #1;
    if (m_busy && rdy) m_busy = 1'b0;
    if (w >= 0) begin
`ifndef AXIL_ARB_PRIO0_EN
      chk("starvation_bound", 64'(wait_cnt[w] <= N - 1), 64'd1);
      for (int i = 0; i < N; i++)
        if (i != w && cur_valid[i]) wait_cnt[i]++;
`endif
      sb.push_back('{w, cur_addr[w], cur_data[w]});
      m_busy = 1'b1;
      m_id   = w;
      m_addr = cur_addr[w];
      m_data = cur_data[w];
`ifdef AXIL_ARB_PRIO0_EN
      if (w != 0) m_ptr = w;
`else
      m_ptr = w;
`endif
      cur_valid[w] = 1'b0;
      if (refill_en) load(w, $urandom, $urandom);
    end
    if (gen_en)
      for (int i = 0; i < N; i++)
        if (!cur_valid[i] && $urandom_range(0, 3) == 0) load(i, $urandom, $urandom);
  endtask

  task automatic drain();
    int n;
    gen_en    = 1'b0;
    refill_en = 1'b0;
    n = 0;
    while ((|cur_valid || m_busy) && n < 200) begin
      cycle(1'b1);
      n++;
    end
    chk("drain_done", 64'({|cur_valid, m_busy}), 64'd0);
  endtask

  // monitor: every downstream handshake must match the oldest accepted request
  always @(negedge clk) begin
    if (!rst && m_cfg_wvalid && m_cfg_wready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_xfer actual=%0h expected=none", m_cfg_waddr);
      end else begin
        xfer_t e;
        e = sb.pop_front();
        chk("sb_addr", 64'(m_cfg_waddr), 64'(e.addr));
        chk("sb_data", 64'(m_cfg_wdata), 64'(e.data));
        chk("sb_id", 64'(grant_id), 64'(e.id));
      end
    end
  end

  initial begin
    rst          = 1'b1;
    req_wvalid   = '1;
    req_waddr    = '0;
    req_wdata    = '0;
    m_cfg_wready = 1'b0;
    gen_en       = 1'b0;
    refill_en    = 1'b0;
    for (int i = 0; i < N; i++) begin
      cur_addr[i] = '0;
      cur_data[i] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_wready", 64'(req_wready), 64'd0);
    chk("rst_m_cfg_wvalid", 64'(m_cfg_wvalid), 64'd0);
    chk("rst_m_cfg_waddr", 64'(m_cfg_waddr), 64'd0);
    chk("rst_m_cfg_wdata", 64'(m_cfg_wdata), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single request from requester 2
    load(2, 32'h10, 32'hA5A5_0001);
    repeat (4) cycle(1'b1);

    // all four requesting continuously
    refill_en = 1'b1;
    for (int i = 0; i < N; i++) load(i, $urandom, $urandom);
    repeat (12) cycle(1'b1);
    drain();

    // backpressure: five stalled cycles with a competing requester waiting
    load(1, 32'h0000_0040, 32'hDEAD_0005);
    cycle(1'b0);
    load(3, 32'h0000_0080, 32'hBEEF_0006);
    repeat (5) cycle(1'b0);
    cycle(1'b1);
    drain();

    // idle: nothing requested, outputs must hold
    repeat (10) cycle(1'($urandom_range(0, 1)));

    // reset while a transfer is pending
    load(2, 32'h0000_0100, 32'h1234_5678);
    cycle(1'b0);
    cycle(1'b0);
    #2;
    rst        = 1'b1;
    req_wvalid = '1;
    #1;
    chk("async_rst_m_cfg_wvalid", 64'(m_cfg_wvalid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_req_wready", 64'(req_wready), 64'd0);
    chk("async_rst_m_cfg_waddr", 64'(m_cfg_waddr), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) load(i, $urandom, $urandom);
    repeat (10) cycle(1'b1);
    drain();

    // randomized traffic with random backpressure
    gen_en = 1'b1;
    for (int n = 0; n < 1500; n++) cycle(1'($urandom_range(0, 2) != 0));
    drain();
    repeat (2) cycle(1'b1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
